cam_wr_sel: RTL

Registered, flow-controlled write-address selector for the parser's CAM array, generalising the combinational address decoder. It accepts explicit or auto-allocated write requests, tracks per-entry occupancy, and presents a one-hot entry select plus binary address to the CAM write port one cycle later. It sits between the tag-insert logic and the CAM storage banks.

---
 rtl/cam_pkg.sv | 17 +
 rtl/cam_wr_sel_if.sv | 42 ++++
 rtl/cam_prio_enc.sv | 24 ++
 rtl/cam_wr_sel.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the CAM write-address selector.
package cam_pkg;

  localparam int CAM_ADDR_W = 5;

  // Number of CAM entries addressed by an address of the given width.
  function automatic int cam_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One write request as seen by the selector.
  typedef struct packed {
    logic                  is_auto;
    logic [CAM_ADDR_W-1:0] addr;
  } cam_req_t;

endpackage

// File: rtl/cam_wr_sel_if.sv
// Request, invalidate, select and status signals between the tag-insert
// logic (master) and the CAM write-address selector (slave).
interface cam_wr_sel_if
  import cam_pkg::*;
#(
  parameter int ADDR_WIDTH = CAM_ADDR_W
) ();

  localparam int CAM_DEPTH = cam_depth(ADDR_WIDTH);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_auto;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic                  inv_valid;
  logic [ADDR_WIDTH-1:0] inv_addr;
  logic                  flush;

  logic                  sel_valid;
  logic                  sel_ready;
  logic [CAM_DEPTH-1:0]  sel_onehot;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_evict;

  logic [CAM_DEPTH-1:0]  occupied;
  logic [ADDR_WIDTH:0]   used_count;
  logic                  full;

  modport master (
    output req_valid, req_auto, req_addr, inv_valid, inv_addr, flush, sel_ready,
    input  req_ready, sel_valid, sel_onehot, sel_addr, sel_evict,
           occupied, used_count, full
  );

  modport slave (
    input  req_valid, req_auto, req_addr, inv_valid, inv_addr, flush, sel_ready,
    output req_ready, sel_valid, sel_onehot, sel_addr, sel_evict,
           occupied, used_count, full
  );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit finder: returns the index of the lowest set bit in vec
// and whether any bit was set at all.
module cam_prio_enc #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_wr_sel.sv
// Registered write-address selector for the parser CAM.
// Accepts explicit or auto-allocated writes, tracks per-entry occupancy and
// presents a one-hot select plus binary address one cycle after acceptance.
// Build option CAM_WR_SEL_FIRST_FREE_EN: auto requests take the lowest free
// entry and stall while full; otherwise auto requests use a ring pointer and
// may overwrite occupied entries (flagged by sel_evict).
module cam_wr_sel
  import cam_pkg::*;
#(
  parameter int ADDR_WIDTH = CAM_ADDR_W
) (
  input logic         clk,
  input logic         rst,
  cam_wr_sel_if.slave bus
);

  localparam int CAM_DEPTH = cam_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  cam_req_t req;

  logic                  sel_valid_q;
  logic [ADDR_WIDTH-1:0] sel_addr_q;
  logic [CAM_DEPTH-1:0]  sel_onehot_q;
  logic                  sel_evict_q;

  logic [CAM_DEPTH-1:0]  occ_q;
  logic [CAM_DEPTH-1:0]  occ_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic                  full_q;

  logic                  auto_block;
  logic [ADDR_WIDTH-1:0] auto_target;
  logic [ADDR_WIDTH-1:0] target;
  logic [CAM_DEPTH-1:0]  target_onehot;
  logic                  ready;
  logic                  accept;
  logic                  prior_occ;
  logic                  inv_dec;

  // Bundle the incoming request fields.
  always_comb begin
    req         = '0;
    req.is_auto = bus.req_auto;
    req.addr    = bus.req_addr;
  end

`ifdef CAM_WR_SEL_FIRST_FREE_EN
  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  free_found;

  cam_prio_enc #(
    .WIDTH (CAM_DEPTH),
    .IDX_W (ADDR_WIDTH)
  ) u_free_enc (
    .vec   (~occ_q),
    .idx   (free_idx),
    .found (free_found)
  );

  // full_q and !free_found agree; both are kept so a stale count can never
  // let an auto write land on an occupied entry.
  assign auto_block  = req.is_auto && (full_q || !free_found);
  assign auto_target = free_idx;
`else
  logic [ADDR_WIDTH-1:0] wr_ptr_q;

  assign auto_block  = 1'b0;
  assign auto_target = wr_ptr_q;

  // Ring pointer: advances only on accepted auto requests, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q <= '0;
    end else if (accept && req.is_auto) begin
      wr_ptr_q <= wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  end
`endif

  assign ready     = !bus.flush && (!sel_valid_q || bus.sel_ready) && !auto_block;
  assign accept    = bus.req_valid && ready;
  assign target    = req.is_auto ? auto_target : req.addr;
  assign prior_occ = occ_q[target];

  // An invalidate only lowers the count if the entry was set and the same
  // cycle's write is not re-claiming it.
  assign inv_dec = bus.inv_valid && occ_q[bus.inv_addr] &&
                   !(accept && (bus.inv_addr == target));

  // Inline one-hot decode of the write target.
  always_comb begin
    target_onehot         = '0;
    target_onehot[target] = 1'b1;
  end

  // Next occupancy and population: invalidate first, write wins, flush overrides.
  always_comb begin
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (bus.inv_valid) begin
      occ_d[bus.inv_addr] = 1'b0;
    end
    if (accept) begin
      occ_d[target] = 1'b1;
    end
    if (accept && !prior_occ) begin
      cnt_d = cnt_d + CNT_ONE;
    end
    if (inv_dec) begin
      cnt_d = cnt_d - CNT_ONE;
    end
    if (bus.flush) begin
      occ_d = '0;
      cnt_d = '0;
    end
  end

  // Occupancy bitmap, count and full flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == DEPTH_CNT);
    end
  end

  // Single-slot output stage; cleared fields keep sel_onehot zero when idle.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      sel_valid_q  <= 1'b0;
      sel_addr_q   <= '0;
      sel_onehot_q <= '0;
      sel_evict_q  <= 1'b0;
    end else if (accept) begin
      sel_valid_q  <= 1'b1;
      sel_addr_q   <= target;
      sel_onehot_q <= target_onehot;
      sel_evict_q  <= prior_occ;
    end else if (sel_valid_q && bus.sel_ready) begin
      sel_valid_q  <= 1'b0;
      sel_addr_q   <= '0;
      sel_onehot_q <= '0;
      sel_evict_q  <= 1'b0;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.sel_addr   = sel_addr_q;
  assign bus.sel_onehot = sel_onehot_q;
  assign bus.sel_evict  = sel_evict_q;
  assign bus.occupied   = occ_q;
  assign bus.used_count = cnt_q;
  assign bus.full       = full_q;

endmodule
